spi_frame_master: RTL and testbench

- Host-side SPI master that serializes one lamp configuration frame toward the lamp's SPI slave input.
- Frame carries lint, red, green, blue, color index, mode and white bytes.
- Lives in the host/test harness companion design; drives the sck/cs/mosi pins that the lamp samples.
- Mode-0 timing, MSB first, cs held low for the whole frame, idle gap between bytes so the receiver can dispatch each byte.

---
 rtl/spi_frame_master.sv | 134 +++++++++++++
 tb/tb_spi_frame_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master: mode-0 SPI master that sends one lamp configuration frame, MSB first.
// Build option: define SPI_FRAME_CHECKSUM_EN to append an XOR checksum byte after byte 6.
module spi_frame_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lint_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  input  logic [7:0] color_idx_in,
  input  logic [7:0] mode_in,
  input  logic [7:0] white_in,
  output logic       sck,
  output logic       cs,
  output logic       mosi,
  output logic       busy,
  output logic       done
);
`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int NB = 8;
`else
  localparam int NB = 7;
`endif
  localparam int CW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] C_END = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_END = GW'(GAP_CYCLES - 1);
  localparam logic [2:0] B_END = 3'(NB - 1);
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HIGH, SCK_LOW, GAP, HOLD, DONE} state_t;
  state_t          state_q;
  logic [7:0]      frame_q [NB];
  logic [CW-1:0]   cnt_q;
  logic [GW-1:0]   gap_q;
  logic [2:0]      byte_q;
  logic [2:0]      bit_q;
  logic            sck_q, cs_q, mosi_q, busy_q, done_q;
  logic            tick;
  logic [7:0]      cur_byte;
  assign tick     = cnt_q == C_END;
  assign cur_byte = frame_q[byte_q];
  assign sck      = sck_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  // Snapshot the frame at acceptance so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset && state_q == IDLE && start) begin
      frame_q[0] <= lint_in;
      frame_q[1] <= red_in;
      frame_q[2] <= green_in;
      frame_q[3] <= blue_in;
      frame_q[4] <= color_idx_in;
      frame_q[5] <= mode_in;
      frame_q[6] <= white_in;
`ifdef SPI_FRAME_CHECKSUM_EN
      frame_q[7] <= lint_in ^ red_in ^ green_in ^ blue_in ^ color_idx_in ^ mode_in ^ white_in;
`endif
    end
  end
  // Frame sequencer; all pin levels are registered and set on state transitions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= (tick || state_q inside {IDLE, GAP, DONE}) ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= SETUP;
          byte_q  <= '0;
          bit_q   <= 3'd7;
          cs_q    <= 1'b0;
          busy_q  <= 1'b1;
          mosi_q  <= lint_in[7];
        end
        SETUP: if (tick) begin
          state_q <= SCK_HIGH;
          sck_q   <= 1'b1;
        end
        SCK_HIGH: if (tick) begin
          state_q <= SCK_LOW;
          sck_q   <= 1'b0;
          mosi_q  <= bit_q == 3'd0 ? 1'b0 : cur_byte[bit_q - 3'd1];
        end
        SCK_LOW: if (tick) begin
          if (bit_q != 3'd0) begin
            state_q <= SCK_HIGH;
            bit_q   <= bit_q - 3'd1;
            sck_q   <= 1'b1;
          end else if (byte_q != B_END) begin
            state_q <= GAP;
            byte_q  <= byte_q + 3'd1;
            bit_q   <= 3'd7;
            gap_q   <= '0;
            mosi_q  <= 1'b0;
          end else begin
            state_q <= HOLD;
          end
        end
        GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == G_END) begin
            state_q <= SETUP;
            gap_q   <= '0;
            mosi_q  <= cur_byte[7];
          end
        end
        HOLD: if (tick) begin
          state_q <= DONE;
          cs_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          mosi_q  <= 1'b0;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_frame_master.sv
// tb_spi_frame_master: scoreboard bench for default and fast-timing spi_frame_master instances.
module tb_spi_frame_master;
`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int NB = 8, LEN = 604, LEN_F = 281;
`else
  localparam int NB = 7, LEN = 528, LEN_F = 246;
`endif
  logic clk = 0, reset = 0, start = 0, start_f = 0;
  logic [7:0] din [7];
  logic sck, cs, mosi, busy, done;
  logic sck_f, cs_f, mosi_f, busy_f, done_f;
  int checks = 0, errors = 0;
  logic [7:0] exp_byte [$];
  int exp_len [$];
  int nbyte = 0, nbit = 0, ndone = 0, cslen = 0, busy_bad = 0;
  logic [7:0] sh = 0;
  logic prev_sck = 0;
  int f_hi = 0, f_lo = 0, f_nhi = 0, f_hi_bad = 0, f_lo_bad = 0, f_gaps = 0, f_len = 0, f_busy_bad = 0, f_done = 0;
  logic f_prev = 0;

  always #5 clk = ~clk;

  spi_frame_master u_dut (
    .clk(clk), .reset(reset), .start(start),
    .lint_in(din[0]), .red_in(din[1]), .green_in(din[2]), .blue_in(din[3]),
    .color_idx_in(din[4]), .mode_in(din[5]), .white_in(din[6]),
    .sck(sck), .cs(cs), .mosi(mosi), .busy(busy), .done(done)
  );

  spi_frame_master #(.CLK_DIV(2), .GAP_CYCLES(1)) u_fast (
    .clk(clk), .reset(reset), .start(start_f),
    .lint_in(din[0]), .red_in(din[1]), .green_in(din[2]), .blue_in(din[3]),
    .color_idx_in(din[4]), .mode_in(din[5]), .white_in(din[6]),
    .sck(sck_f), .cs(cs_f), .mosi(mosi_f), .busy(busy_f), .done(done_f)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Byte capture on rising sck and frame-level checks when done pulses.
  always @(negedge clk) begin
    if (!reset) begin
      nbit = 0; cslen = 0; busy_bad = 0; prev_sck = 0;
    end else begin
      if (sck && !prev_sck) begin
        sh = {sh[6:0], mosi};
        nbit++;
        if (nbit == 8) begin
          nbit = 0;
          nbyte++;
          chk("byte", sh, exp_byte.size() > 0 ? int'(exp_byte.pop_front()) : -1);
        end
      end
      if (!cs) begin
        cslen++;
        if (!busy) busy_bad++;
      end
      if (done) begin
        ndone++;
        chk("cs_len", cslen, exp_len.size() > 0 ? exp_len.pop_front() : -1);
        chk("busy_in_frame", busy_bad, 0);
        chk("done_cs_high", cs, 1);
        cslen = 0; busy_bad = 0;
      end
      prev_sck = sck;
    end
  end

  // Phase-length measurement on the CLK_DIV=2, GAP_CYCLES=1 instance.
  always @(negedge clk) begin
    if (!reset) begin
      f_hi = 0; f_lo = 0; f_nhi = 0; f_hi_bad = 0; f_lo_bad = 0; f_gaps = 0; f_len = 0; f_busy_bad = 0; f_prev = 0;
    end else begin
      if (!cs_f) begin
        f_len++;
        if (!busy_f) f_busy_bad++;
        if (sck_f) begin
          if (!f_prev) begin
            if (f_lo == 5) f_gaps++;
            else if (f_lo != 2) f_lo_bad++;
            f_lo = 0;
          end
          f_hi++;
        end else begin
          if (f_prev) begin
            if (f_hi != 2) f_hi_bad++;
            f_nhi++;
            f_hi = 0;
          end
          f_lo++;
        end
      end
      if (done_f) begin
        f_done++;
        chk("fast_len", f_len, LEN_F);
        chk("fast_hi_runs", f_nhi, NB * 8);
        chk("fast_hi_bad", f_hi_bad, 0);
        chk("fast_lo_bad", f_lo_bad, 0);
        chk("fast_gaps", f_gaps, NB - 1);
        chk("fast_busy_bad", f_busy_bad, 0);
        chk("fast_done_mosi", mosi_f, 0);
        f_hi = 0; f_lo = 0; f_nhi = 0; f_hi_bad = 0; f_lo_bad = 0; f_gaps = 0; f_len = 0; f_busy_bad = 0;
      end
      f_prev = sck_f;
    end
  end

  task automatic pulse(input logic [55:0] v, input bit push);
    logic [7:0] x = 0;
    for (int i = 0; i < 7; i++) din[i] = v[55 - 8 * i -: 8];
    if (push) begin
      for (int i = 0; i < 7; i++) begin
        exp_byte.push_back(din[i]);
        x ^= din[i];
      end
`ifdef SPI_FRAME_CHECKSUM_EN
      exp_byte.push_back(x);
`endif
      exp_len.push_back(LEN);
    end
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int n0, input string name);
    int i = 0;
    while (ndone == n0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk(name, ndone - n0, 1);
  endtask

  initial begin
    int n0, b0, i;
    for (int k = 0; k < 7; k++) din[k] = 0;
    repeat (3) @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_cs", cs, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs_fast", cs_f, 1);
    reset = 1;
    repeat (5) @(negedge clk);
    chk("idle_cs", cs, 1);
    chk("idle_busy", busy, 0);

    n0 = ndone;
    pulse(56'hA5_01_80_FF_00_3C_7E, 1);
    chk("busy_after_start", busy, 1);
    chk("cs_after_start", cs, 0);
    wait_done(n0, "done_A");
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_width", done, 0);

    n0 = ndone;
    pulse(56'h11_22_33_44_55_66_77, 1);
    repeat (98) @(negedge clk);
    pulse(56'hDE_AD_BE_EF_CA_FE_99, 0);
    wait_done(n0, "done_B");
    repeat (LEN + 50) @(negedge clk);
    chk("single_done_B", ndone - n0, 1);

    n0 = ndone;
    b0 = nbyte;
    pulse(56'hC3_5A_0F_F0_81_42_24, 1);
    i = 0;
    while (!(nbyte == b0 + 3 && nbit == 4) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk("reach_b3_bit4", nbyte - b0, 3);
    reset = 0;
    @(negedge clk);
    chk("mid_rst_cs", cs, 1);
    chk("mid_rst_sck", sck, 0);
    chk("mid_rst_mosi", mosi, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    reset = 1;
    exp_byte.delete();
    exp_len.delete();
    repeat (LEN) @(negedge clk);
    chk("no_done_after_reset", ndone - n0, 0);

    n0 = ndone;
    pulse(56'h01_02_03_04_05_06_07, 1);
    wait_done(n0, "done_D");
    repeat (5) @(negedge clk);

    n0 = f_done;
    start_f = 1;
    @(negedge clk);
    start_f = 0;
    i = 0;
    while (f_done == n0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("fast_done", f_done - n0, 1);

    chk("queue_empty", exp_byte.size() + exp_len.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
